// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit asynchronous serial transmitter with selectable baud rate.
//
// Frame: start (0), Tx_DATA[0]..Tx_DATA[7] LSB first, optional even parity, stop (1).
// Each bit lasts 16 ticks of an internal tick generator whose period is
// DIV = round(CLK_FREQ / (16 * baud)) clocks.
//
// Configuration macro:
//   UART_TX_PARITY_EN  defined   -> 11-bit frame with even parity bit (XOR of data)
//                      undefined -> 10-bit frame, no parity bit
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   Tx_DATA      byte to send, sampled only on an accepted write
//   baud_select  000=300 001=1200 010=4800 011=9600 100=19200 101=38400
//                110=57600 111=115200, latched on an accepted write
//   Tx_EN        writes accepted only while high (does not abort a running frame)
//   Tx_WR        single-cycle write strobe, honoured only in idle
//   TxD          registered serial output, idle high
//   Tx_BUSY      high from the cycle after an accepted write until the stop bit ends

module uart_transmitter #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  output logic       TxD,
  output logic       Tx_BUSY
);

  // Rounded divisor; never below 1 so the tick generator always advances.
  function automatic int unsigned calc_div(input int unsigned baud);
    int unsigned div;
    div = (CLK_FREQ + 8 * baud) / (16 * baud);
    return (div == 0) ? 1 : div;
  endfunction

  localparam int unsigned Div300    = calc_div(300);
  localparam int unsigned Div1200   = calc_div(1200);
  localparam int unsigned Div4800   = calc_div(4800);
  localparam int unsigned Div9600   = calc_div(9600);
  localparam int unsigned Div19200  = calc_div(19200);
  localparam int unsigned Div38400  = calc_div(38400);
  localparam int unsigned Div57600  = calc_div(57600);
  localparam int unsigned Div115200 = calc_div(115200);

  // The slowest rate has the largest divisor and sets the counter width.
  localparam int unsigned DivW = $clog2(Div300 + 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd4
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [3:0]        tick_cnt_q, tick_cnt_d;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic [DivW-1:0]   div_sel;
  logic              tick;
  logic              bit_end;
  logic              accept;

  // Divisor for the currently presented baud_select; only captured on accept.
  always_comb begin
    unique case (baud_select)
      3'd0: div_sel = DivW'(Div300);
      3'd1: div_sel = DivW'(Div1200);
      3'd2: div_sel = DivW'(Div4800);
      3'd3: div_sel = DivW'(Div9600);
      3'd4: div_sel = DivW'(Div19200);
      3'd5: div_sel = DivW'(Div38400);
      3'd6: div_sel = DivW'(Div57600);
      3'd7: div_sel = DivW'(Div115200);
    endcase
  end

  assign tick    = (div_cnt_q == (div_q - DivW'(1)));
  assign bit_end = tick && (tick_cnt_q == 4'd15);
  assign accept  = (state_q == StIdle) && Tx_WR && Tx_EN;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    tick_cnt_d = tick_cnt_q;
    div_cnt_d  = div_cnt_q;
    div_d      = div_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    // Tick generator and per-bit tick counter run whenever a frame is active;
    // the 4-bit tick counter wraps to zero naturally at the end of each bit.
    if (state_q != StIdle) begin
      if (tick) begin
        div_cnt_d  = '0;
        tick_cnt_d = tick_cnt_q + 4'd1;
      end else begin
        div_cnt_d  = div_cnt_q + DivW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        txd_d      = 1'b1;
        busy_d     = 1'b0;
        div_cnt_d  = '0;
        tick_cnt_d = '0;
        if (accept) begin
          state_d   = StStart;
          shift_d   = Tx_DATA;
          div_d     = div_sel;
          bit_idx_d = '0;
          txd_d     = 1'b0;
          busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^Tx_DATA;
`endif
        end
      end

      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end
      end

      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            txd_d   = parity_q;
`else
            state_d = StStop;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          txd_d   = 1'b1;
        end
      end
`endif

      StStop: begin
        // A write arriving on this last edge is dropped: state is not yet idle.
        if (bit_end) begin
          state_d = StIdle;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tick_cnt_q <= '0;
      div_cnt_q  <= '0;
      div_q      <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tick_cnt_q <= tick_cnt_d;
      div_cnt_q  <= div_cnt_d;
      div_q      <= div_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: self-checking bench for uart_transmitter at 50 MHz.
// Frames are compared cycle by cycle against an expected bit list built from the
// data byte, with bit length taken from a table of rounded divisors.

module tb_uart_transmitter;

  localparam int unsigned ClkFreq = 50_000_000;
`ifdef UART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] Tx_DATA = 8'h00;
  logic [2:0] baud_select = 3'b111;
  logic       Tx_EN = 1'b0;
  logic       Tx_WR = 1'b0;
  logic       TxD;
  logic       Tx_BUSY;

  int checks = 0;
  int failures = 0;
  int div_tab [8];

  typedef struct {
    logic [7:0] data;
    logic [2:0] bsel;
    int         exp_bitlen;
    logic       exp_par;
    int         wr2_cyc;
    logic [7:0] wr2_data;
    int         en_drop_cyc;
    int         bsel_chg_cyc;
    bit         wr_at_stop;
  } vec_t;

  vec_t vecs [7];

  uart_transmitter #(.CLK_FREQ(ClkFreq)) dut (
    .clk         (clk),
    .reset       (reset),
    .Tx_DATA     (Tx_DATA),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sends one byte and checks every clock of the frame plus a short idle window.
  task automatic run_frame(input string name, input logic [7:0] data, input logic [2:0] bsel,
                           input int bitlen, input logic par, input int wr2_cyc,
                           input logic [7:0] wr2_data, input int en_drop_cyc,
                           input int bsel_chg_cyc, input bit wr_at_stop);
    logic exp_bits [11];
    int   bit_err [11];
    int   busy_err;
    int   idle_err;
    int   n;
    int   b;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i + 1] = data[i];
    exp_bits[9]  = (NBits == 11) ? par : 1'b1;
    exp_bits[10] = 1'b1;
    for (int i = 0; i < 11; i++) bit_err[i] = 0;
    busy_err = 0;
    idle_err = 0;
    n = NBits * bitlen;

    @(negedge clk);
    Tx_DATA     = data;
    baud_select = bsel;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b1;
    check_eq({name, " pre TxD"}, int'(TxD), 1);
    check_eq({name, " pre busy"}, int'(Tx_BUSY), 0);

    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      b = c / bitlen;
      if (TxD !== exp_bits[b]) bit_err[b]++;
      if (Tx_BUSY !== 1'b1) busy_err++;
      if (c == 0) begin
        Tx_WR   = 1'b0;
        Tx_DATA = ~data;
      end
      if (c == wr2_cyc) begin
        Tx_WR   = 1'b1;
        Tx_DATA = wr2_data;
      end
      if (c == wr2_cyc + 1) Tx_WR = 1'b0;
      if (c == en_drop_cyc) Tx_EN = 1'b0;
      if (c == bsel_chg_cyc) baud_select = ~bsel;
      if (wr_at_stop && c == n - 1) begin
        Tx_WR   = 1'b1;
        Tx_DATA = 8'h00;
      end
    end

    for (int i = 0; i < NBits; i++)
      check_eq($sformatf("%s bit%0d wrong cycles (level %b)", name, i, exp_bits[i]),
               bit_err[i], 0);
    check_eq({name, " busy drops"}, busy_err, 0);

    @(negedge clk);
    Tx_WR = 1'b0;
    check_eq({name, " end TxD"}, int'(TxD), 1);
    check_eq({name, " end busy"}, int'(Tx_BUSY), 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) idle_err++;
      if (en_drop_cyc >= 0 && k == 2) Tx_WR = 1'b1;
      if (k == 3) Tx_WR = 1'b0;
    end
    check_eq({name, " idle after frame"}, idle_err, 0);
    Tx_EN = 1'b1;
  endtask

  // Measures the start bit of a frame, then aborts it with an asynchronous reset.
  task automatic start_len(input logic [2:0] bsel);
    int cnt;
    @(negedge clk);
    Tx_DATA     = 8'hFF;
    baud_select = bsel;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    cnt   = 0;
    while (TxD === 1'b0 && cnt < 20000) begin
      cnt++;
      @(negedge clk);
    end
    check_eq($sformatf("start bit length bsel=%0d", bsel), cnt, 16 * div_tab[bsel]);
    #2 reset = 1'b0;
    #1;
    check_eq("abort reset TxD", int'(TxD), 1);
    check_eq("abort reset busy", int'(Tx_BUSY), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int bad;
    logic [7:0] rd;

    div_tab = '{10417, 2604, 651, 326, 163, 81, 54, 27};
    //          data   bsel  bitlen par wr2  wr2d   endrop bselchg stopwr
    vecs[0] = '{8'hA5, 3'd7, 432, 1'b0, -1, 8'h00, -1, -1, 1'b0};
    vecs[1] = '{8'h07, 3'd7, 432, 1'b1, -1, 8'h00, -1, -1, 1'b0};
    vecs[2] = '{8'h00, 3'd7, 432, 1'b0, -1, 8'h00, -1, -1, 1'b0};
    vecs[3] = '{8'h3C, 3'd7, 432, 1'b0, 100, 8'hFF, -1, -1, 1'b0};
    vecs[4] = '{8'h5A, 3'd7, 432, 1'b0, -1, 8'h00, 2000, -1, 1'b0};
    vecs[5] = '{8'hC3, 3'd7, 432, 1'b0, -1, 8'h00, -1, 500, 1'b0};
    vecs[6] = '{8'h97, 3'd6, 864, 1'b1, -1, 8'h00, -1, -1, 1'b1};

    // Reset state
    #2 reset = 1'b0;
    #1;
    check_eq("reset TxD", int'(TxD), 1);
    check_eq("reset busy", int'(Tx_BUSY), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    Tx_EN = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post-reset TxD", int'(TxD), 1);

    // Writes with Tx_EN low are rejected
    @(negedge clk);
    Tx_EN   = 1'b0;
    Tx_WR   = 1'b1;
    Tx_DATA = 8'h00;
    @(negedge clk);
    Tx_WR = 1'b0;
    bad   = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad++;
    end
    check_eq("disabled write ignored", bad, 0);
    Tx_EN = 1'b1;

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].bsel, vecs[i].exp_bitlen,
                vecs[i].exp_par, vecs[i].wr2_cyc, vecs[i].wr2_data, vecs[i].en_drop_cyc,
                vecs[i].bsel_chg_cyc, vecs[i].wr_at_stop);

    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom);
      run_frame($sformatf("rand%0d", i), rd, 3'd7, 16 * div_tab[7], ^rd,
                int'($urandom_range(1, 4000)), 8'($urandom),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4000)) : -1,
                int'($urandom_range(1, 4000)), 1'b0);
    end

    // Divisors of slower rates via start bit length
    start_len(3'd3);
    start_len(3'd4);
    start_len(3'd5);

    // Reset in the middle of data bit 4, then a clean frame
    @(negedge clk);
    Tx_DATA     = 8'hEF;
    baud_select = 3'd7;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    repeat (5 * 432 + 216) @(negedge clk);
    check_eq("data bit4 before reset", int'(TxD), 0);
    #2 reset = 1'b0;
    #1;
    check_eq("mid-frame reset TxD", int'(TxD), 1);
    check_eq("mid-frame reset busy", int'(Tx_BUSY), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("after reset 55", 8'h55, 3'd7, 432, 1'b0, -1, 8'h00, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
